// File: rtl/apb_master_bridge_if.sv
// Command/response stream and APB4 bus signals of apb_master_bridge.
// The master modport is the bridge side; the slave modport is the requester plus completer side.
interface apb_master_bridge_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_write_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_strb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] paddr_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i,
        input  rsp_ready_i, pready_i, prdata_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i,
        output rsp_ready_i, pready_i, prdata_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB4 initiator; every output is a register.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that never see pready_i.
module apb_master_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 pclk_i,
    input  logic                 presetn_i,
    apb_master_bridge_if.master  bus
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic        psel_q;
    logic        penable_q;
    logic        pwrite_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic [3:0]  pstrb_q;
    logic        access_done;
    logic        access_err;
    logic [31:0] access_rdata;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_cnt_q;
    logic        timeout_hit;

    // A late pready_i on the limit cycle still wins over the abort.
    assign timeout_hit = !bus.pready_i && (wait_cnt_q == TIMEOUT_LIM);
    assign access_done = bus.pready_i || timeout_hit;
`else
    assign access_done = bus.pready_i;
`endif

    assign access_err   = bus.pready_i ? bus.pslverr_i : 1'b1;
    assign access_rdata = (bus.pready_i && !pwrite_q && !bus.pslverr_i) ? bus.prdata_i : 32'd0;

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'd0;
            pwdata_q    <= 32'd0;
            pstrb_q     <= 4'd0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q  <= 16'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_ready_q && bus.req_valid_i) begin
                        req_ready_q <= 1'b0;
                        if (bus.req_addr_i[1:0] != 2'b00) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                        end else begin
                            // The APB output registers double as the command latch.
                            state_q  <= SETUP;
                            psel_q   <= 1'b1;
                            paddr_q  <= bus.req_addr_i;
                            pwrite_q <= bus.req_write_i;
                            pwdata_q <= bus.req_write_i ? bus.req_wdata_i : 32'd0;
                            pstrb_q  <= bus.req_write_i ? bus.req_strb_i : 4'd0;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt_q <= 16'd0;
`endif
                end
                ACCESS: begin
                    if (access_done) begin
                        state_q     <= RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        pwrite_q    <= 1'b0;
                        paddr_q     <= 32'd0;
                        pwdata_q    <= 32'd0;
                        pstrb_q     <= 4'd0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= access_err;
                        rsp_rdata_q <= access_rdata;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = req_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.psel_o      = psel_q;
    assign bus.penable_o   = penable_q;
    assign bus.pwrite_o    = pwrite_q;
    assign bus.paddr_o     = paddr_q;
    assign bus.pwdata_o    = pwdata_q;
    assign bus.pstrb_o     = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed commands, a configurable completer
// model and a monitor that checks APB phases and responses against queued expectations.
module tb_apb_master_bridge;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    apb_master_bridge_if bus();

    apb_master_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .pclk_i    (clk),
        .presetn_i (rstn),
        .bus       (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct { logic [31:0] rdata; logic err; } rsp_t;
    typedef struct { logic [31:0] addr; logic write; logic [31:0] wdata; logic [3:0] strb; } apb_t;

    rsp_t exp_rsp_q[$];
    apb_t exp_apb_q[$];
    apb_t cur_apb;
    int   rsp_cnt    = 0;
    int   access_cnt = 0;
    int   valid_cyc  = 0;
    logic prev_valid = 1'b0;

    // Completer model: ready after cfg_wait ACCESS cycles; junk on every undriven cycle.
    int          cfg_wait  = 0;
    logic [31:0] cfg_rdata = 32'd0;
    logic        cfg_err   = 1'b0;
    logic        cfg_never = 1'b0;
    int          cpl_k     = 0;

    always @(negedge clk) begin
        if (bus.psel_o && bus.penable_o) begin
            if (!cfg_never && cpl_k >= cfg_wait) begin
                bus.pready_i  = 1'b1;
                bus.prdata_i  = cfg_rdata;
                bus.pslverr_i = cfg_err;
            end else begin
                bus.pready_i  = 1'b0;
                bus.prdata_i  = 32'h5A5A5A5A;
                bus.pslverr_i = 1'b1;
            end
            cpl_k++;
        end else begin
            cpl_k         = 0;
            bus.pready_i  = 1'b1;
            bus.prdata_i  = 32'hFFFF0000;
            bus.pslverr_i = 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT shows a SETUP phase or a response handshake.
    always @(negedge clk) begin
        if (bus.psel_o && !bus.penable_o) begin
            if (exp_apb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_setup: paddr 0x%08h, expected no APB cycle", bus.paddr_o);
            end else begin
                cur_apb = exp_apb_q.pop_front();
                check("setup_addr_wdata", {bus.paddr_o, bus.pwdata_o}, {cur_apb.addr, cur_apb.wdata});
                check("setup_write_strb", {bus.pwrite_o, bus.pstrb_o}, {cur_apb.write, cur_apb.strb});
            end
            access_cnt = 0;
        end
        if (bus.psel_o && bus.penable_o) begin
            access_cnt++;
            check("access_addr_wdata", {bus.paddr_o, bus.pwdata_o}, {cur_apb.addr, cur_apb.wdata});
            check("access_write_strb", {bus.pwrite_o, bus.pstrb_o}, {cur_apb.write, cur_apb.strb});
        end
        if (bus.rsp_valid_o && !prev_valid) valid_cyc = cyc;
        prev_valid = bus.rsp_valid_o;
        if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (exp_rsp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: rdata 0x%08h err %0b, expected no response",
                         bus.rsp_rdata_o, bus.rsp_err_o);
            end else begin
                rsp_t e;
                e = exp_rsp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata_o, e.rdata);
                check("rsp_err", bus.rsp_err_o, e.err);
            end
            rsp_cnt++;
        end
    end

    task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, output int acc_cyc);
        int n;
        @(negedge clk);
        bus.req_addr_i  = addr;
        bus.req_write_i = wr;
        bus.req_wdata_i = wdata;
        bus.req_strb_i  = strb;
        bus.req_valid_i = 1'b1;
        n = 0;
        while (!bus.req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: req_ready_o stayed 0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (rsp_cnt < target) begin
            tests++;
            fails++;
            $display("FAIL rsp_timeout: %0d responses, expected %0d", rsp_cnt, target);
        end
    endtask

    typedef struct {
        logic [31:0] addr; logic wr; logic [31:0] wdata; logic [3:0] strb;
        int wait_st; logic [31:0] cpl_rdata; logic cpl_err;
        logic [31:0] exp_rdata; logic exp_err; logic [31:0] exp_pwdata; logic [3:0] exp_pstrb;
        int exp_lat; bit apb;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        int acc;
        int n;
        int prev_rsp;

        vecs[0] = '{32'h0,  1'b1, 32'h12345678, 4'hF, 0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h12345678, 4'hF, 3, 1'b1};
        vecs[1] = '{32'h4,  1'b0, 32'hCAFEF00D, 4'hF, 2, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        4'h0, 5, 1'b1};
        vecs[2] = '{32'h8,  1'b0, 32'h0,        4'h0, 0, 32'h11112222, 1'b1, 32'h0,        1'b1, 32'h0,        4'h0, 3, 1'b1};
        vecs[3] = '{32'h2,  1'b1, 32'h87654321, 4'hF, 0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        4'h0, 1, 1'b0};
        vecs[4] = '{32'h10, 1'b1, 32'hA5A50F0F, 4'h5, 1, 32'h33334444, 1'b1, 32'h0,        1'b1, 32'hA5A50F0F, 4'h5, 4, 1'b1};
        vecs[5] = '{32'h3,  1'b0, 32'h0,        4'h0, 0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        4'h0, 1, 1'b0};
        vecs[6] = '{32'h14, 1'b1, 32'h0000BEEF, 4'h3, 3, 32'h77778888, 1'b0, 32'h0,        1'b0, 32'h0000BEEF, 4'h3, 6, 1'b1};
        vecs[7] = '{32'h28, 1'b0, 32'h0,        4'h0, 0, 32'h600DCAFE, 1'b0, 32'h600DCAFE, 1'b0, 32'h0,        4'h0, 3, 1'b1};

        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = 32'd0;
        bus.req_write_i = 1'b0;
        bus.req_wdata_i = 32'd0;
        bus.req_strb_i  = 4'd0;
        bus.rsp_ready_i = 1'b1;
        bus.pready_i    = 1'b1;
        bus.prdata_i    = 32'd0;
        bus.pslverr_i   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_req_ready", bus.req_ready_o, 1'b0);
        check("reset_psel_penable", {bus.psel_o, bus.penable_o, bus.rsp_valid_o}, 3'b000);
        check("reset_paddr_rdata", {bus.paddr_o, bus.rsp_rdata_o}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", bus.req_ready_o, 1'b1);

        // Directed vectors, one response each
        for (int i = 0; i < 7; i++) begin
            cfg_wait  = vecs[i].wait_st;
            cfg_rdata = vecs[i].cpl_rdata;
            cfg_err   = vecs[i].cpl_err;
            exp_rsp_q.push_back('{vecs[i].exp_rdata, vecs[i].exp_err});
            if (vecs[i].apb)
                exp_apb_q.push_back('{vecs[i].addr, vecs[i].wr, vecs[i].exp_pwdata, vecs[i].exp_pstrb});
            access_cnt = 0;
            prev_rsp = rsp_cnt;
            send(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, acc);
            wait_rsp(prev_rsp + 1);
            $display("[TB] txn %0d addr 0x%08h wr %0b -> latency %0d access %0d",
                     i, vecs[i].addr, vecs[i].wr, valid_cyc - acc + 1, access_cnt);
            check("rsp_latency", valid_cyc - acc + 1, vecs[i].exp_lat);
            check("access_cycles", access_cnt, vecs[i].apb ? vecs[i].wait_st + 1 : 0);
            @(negedge clk);
            check("idle_outputs", {bus.req_ready_o, bus.rsp_err_o, bus.rsp_rdata_o, bus.paddr_o},
                  {1'b1, 1'b0, 32'd0, 32'd0});
        end

        // Response back-pressure with a second request waiting
        cfg_wait  = 0;
        cfg_rdata = 32'h0BADF00D;
        cfg_err   = 1'b0;
        bus.rsp_ready_i = 1'b0;
        exp_rsp_q.push_back('{32'h0BADF00D, 1'b0});
        exp_apb_q.push_back('{32'hC, 1'b0, 32'h0, 4'h0});
        prev_rsp = rsp_cnt;
        send(32'hC, 1'b0, 32'h0, 4'h0, acc);
        n = 0;
        while (!bus.rsp_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_rsp_seen", bus.rsp_valid_o, 1'b1);
        bus.req_addr_i  = 32'h18;
        bus.req_write_i = 1'b1;
        bus.req_wdata_i = 32'h00C0FFEE;
        bus.req_strb_i  = 4'h3;
        bus.req_valid_i = 1'b1;
        exp_rsp_q.push_back('{32'h0, 1'b0});
        exp_apb_q.push_back('{32'h18, 1'b1, 32'h00C0FFEE, 4'h3});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_hold", {bus.rsp_valid_o, bus.req_ready_o, bus.rsp_err_o, bus.rsp_rdata_o},
                  {1'b1, 1'b0, 1'b0, 32'h0BADF00D});
        end
        check("stall_no_setup", bus.psel_o, 1'b0);
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b1;
        n = 0;
        while (!bus.req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        $display("[TB] stalled read 0xC then write 0x18 accepted after %0d responses", rsp_cnt - prev_rsp);
        check("accept_after_handshake", rsp_cnt - prev_rsp, 1);
        wait_rsp(prev_rsp + 2);

`ifdef APB_MASTER_TIMEOUT_EN
        // Completer never ready: abort after TIMEOUT_CYCLES+1 ACCESS cycles
        cfg_never = 1'b1;
        exp_rsp_q.push_back('{32'h0, 1'b1});
        exp_apb_q.push_back('{32'h20, 1'b0, 32'h0, 4'h0});
        prev_rsp = rsp_cnt;
        send(32'h20, 1'b0, 32'h0, 4'h0, acc);
        wait_rsp(prev_rsp + 1);
        $display("[TB] timeout read 0x20 -> access %0d latency %0d", access_cnt, valid_cyc - acc + 1);
        check("timeout_access_cycles", access_cnt, 5);
        check("timeout_latency", valid_cyc - acc + 1, 7);
        cfg_never = 1'b0;
`endif

        // Reset asserted during ACCESS: bus drops at once, no response
        cfg_never = 1'b1;
        exp_rsp_q.push_back('{32'h0, 1'b0});
        exp_apb_q.push_back('{32'h24, 1'b0, 32'h0, 4'h0});
        prev_rsp = rsp_cnt;
        send(32'h24, 1'b0, 32'h0, 4'h0, acc);
        n = 0;
        while (!(bus.psel_o && bus.penable_o) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_in_access", {bus.psel_o, bus.penable_o}, 2'b11);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_bus", {bus.psel_o, bus.penable_o, bus.paddr_o}, {2'b00, 32'd0});
        check("async_reset_handshake", {bus.req_ready_o, bus.rsp_valid_o}, 2'b00);
        void'(exp_rsp_q.pop_back());
        @(negedge clk);
        rstn = 1'b1;
        cfg_never = 1'b0;
        repeat (5) @(negedge clk);
        $display("[TB] reset during ACCESS -> responses %0d after reset", rsp_cnt - prev_rsp);
        check("no_rsp_after_reset", rsp_cnt - prev_rsp, 0);
        check("ready_after_reset", {bus.req_ready_o, bus.rsp_valid_o}, 2'b10);

        // Recovery transfer
        cfg_wait  = vecs[7].wait_st;
        cfg_rdata = vecs[7].cpl_rdata;
        cfg_err   = vecs[7].cpl_err;
        exp_rsp_q.push_back('{vecs[7].exp_rdata, vecs[7].exp_err});
        exp_apb_q.push_back('{vecs[7].addr, vecs[7].wr, vecs[7].exp_pwdata, vecs[7].exp_pstrb});
        prev_rsp = rsp_cnt;
        send(vecs[7].addr, vecs[7].wr, vecs[7].wdata, vecs[7].strb, acc);
        wait_rsp(prev_rsp + 1);
        $display("[TB] txn 7 addr 0x%08h wr %0b -> latency %0d", vecs[7].addr, vecs[7].wr, valid_cyc - acc + 1);
        check("recovery_latency", valid_cyc - acc + 1, vecs[7].exp_lat);
        check("queues_drained", exp_rsp_q.size() + exp_apb_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
